// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - byte receive FIFO, show-ahead read, sticky overrun.
// Optional RX_FIFO_DROP_ERR_EN discards frame-errored bytes and pulses err_drop_o.
module rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_valid_i,
    input  logic [7:0]    wr_data_i,
    input  logic          wr_frame_err_i,
    input  logic          rd_ready_i,
    input  logic          clr_overrun_i,
    output logic          rd_valid_o,
    output logic [7:0]    rd_data_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          overrun_o,
    output logic          err_drop_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          wr_store;
    logic          wr_fire;
    logic          rd_fire;
    logic          overflow;

`ifdef RX_FIFO_DROP_ERR_EN
    logic err_drop_q, err_drop_d;

    assign wr_store   = wr_valid_i & ~wr_frame_err_i;
    assign err_drop_d = wr_valid_i & wr_frame_err_i;
    assign err_drop_o = err_drop_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_drop_q <= 1'b0;
        end else begin
            err_drop_q <= err_drop_d;
        end
    end
`else
    logic unused_frame_err;

    assign unused_frame_err = wr_frame_err_i;
    assign wr_store         = wr_valid_i;
    assign err_drop_o       = 1'b0;
`endif

    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign overrun_o  = overrun_q;

    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign rd_fire  = rd_valid_o & rd_ready_i;
    assign wr_fire  = wr_store & (~full_o | rd_fire);
    assign overflow = wr_store & full_o & ~rd_fire;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (overflow) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire && !rst_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_rx_fifo.sv
// tb/tb_rx_fifo.sv - directed vector table plus hand sequences for rx_fifo.
module tb_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_frame_err = 1'b0;
    logic       rd_ready = 1'b0;
    logic       clr_overrun = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       full;
    logic       overrun;
    logic       err_drop;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       fe;
        logic       rr;
        logic       clr;
        int         e_count;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_full;
        logic       e_ovr;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] model_q[$];

    rx_fifo #(.DEPTH(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_valid_i     (wr_valid),
        .wr_data_i      (wr_data),
        .wr_frame_err_i (wr_frame_err),
        .rd_ready_i     (rd_ready),
        .clr_overrun_i  (clr_overrun),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data),
        .count_o        (count),
        .full_o         (full),
        .overrun_o      (overrun),
        .err_drop_o     (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [7:0] wd, input logic fe,
                         input logic rr, input logic clr);
        wr_valid = wv; wr_data = wd; wr_frame_err = fe; rd_ready = rr; clr_overrun = clr;
        @(posedge clk);
        #1;
        wr_valid = 1'b0; wr_frame_err = 1'b0; rd_ready = 1'b0; clr_overrun = 1'b0;
    endtask

    function automatic vec_t mk(logic wv, logic [7:0] wd, logic fe, logic rr, logic clr,
                                int ec, logic ev, logic [7:0] ed, logic ef, logic eo, logic ee);
        vec_t v;
        v.wv = wv; v.wd = wd; v.fe = fe; v.rr = rr; v.clr = clr;
        v.e_count = ec; v.e_valid = ev; v.e_data = ed; v.e_full = ef; v.e_ovr = eo; v.e_err = ee;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // basic ordering, empty read, frame-error handling, simultaneous r/w
        tbl.push_back(mk(1, 8'h95, 0, 0, 0, 1, 1, 8'h95, 0, 0, 0));
        tbl.push_back(mk(1, 8'h3C, 0, 0, 0, 2, 1, 8'h95, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 1, 8'h3C, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
`ifdef RX_FIFO_DROP_ERR_EN
        tbl.push_back(mk(1, 8'h41, 1, 0, 0, 0, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 0, 0, 1, 1, 8'h22, 0, 0, 0));
`else
        tbl.push_back(mk(1, 8'h41, 1, 0, 0, 1, 1, 8'h41, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 0, 0, 1, 1, 8'h22, 0, 0, 0));
`endif
        tbl.push_back(mk(1, 8'h33, 0, 1, 0, 1, 1, 8'h33, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));

        // reset state
        #2;
        check("async_reset_count", int'(count), 0);
        check("async_reset_valid", int'(rd_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_full", int'(full), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_err_drop", int'(err_drop), 0);

        foreach (tbl[i]) begin
            drive(tbl[i].wv, tbl[i].wd, tbl[i].fe, tbl[i].rr, tbl[i].clr);
            check($sformatf("v%0d_count", i), int'(count), tbl[i].e_count);
            check($sformatf("v%0d_valid", i), int'(rd_valid), int'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                check($sformatf("v%0d_data", i), int'(rd_data), int'(tbl[i].e_data));
            check($sformatf("v%0d_full", i), int'(full), int'(tbl[i].e_full));
            check($sformatf("v%0d_ovr", i), int'(overrun), int'(tbl[i].e_ovr));
            check($sformatf("v%0d_err", i), int'(err_drop), int'(tbl[i].e_err));
        end

        // fill to 16, 17th byte is dropped and sets overrun
        do_reset();
        for (int i = 0; i < 16; i++) drive(1, 8'(i), 0, 0, 0);
        check("fill_count", int'(count), 16);
        check("fill_full", int'(full), 1);
        check("fill_ovr_before", int'(overrun), 0);
        drive(1, 8'h10, 0, 0, 0);
        check("overflow_count", int'(count), 16);
        check("overflow_ovr", int'(overrun), 1);
        drive(0, 8'h00, 0, 0, 1);
        check("clr_ovr", int'(overrun), 0);
        drive(1, 8'h77, 0, 0, 1);
        check("set_beats_clr", int'(overrun), 1);
        drive(0, 8'h00, 0, 0, 1);
        check("clr_ovr2", int'(overrun), 0);
        check("full_head", int'(rd_data), 8'h00);
        drive(1, 8'hAA, 0, 1, 0);
        check("full_rw_count", int'(count), 16);
        check("full_rw_ovr", int'(overrun), 0);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain_%0d", i), int'(rd_data), (i == 16) ? 8'hAA : i);
            drive(0, 8'h00, 0, 1, 0);
        end
        check("drain_count", int'(count), 0);
        check("drain_valid", int'(rd_valid), 0);

        // 40 write/read pairs at COUNT=3 wrap both pointers
        model_q.delete();
        for (int i = 0; i < 3; i++) begin
            model_q.push_back(8'hC0 + 8'(i));
            drive(1, 8'hC0 + 8'(i), 0, 0, 0);
        end
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = 8'(i * 37 + 5);
            check($sformatf("pair_%0d", i), int'(rd_data), int'(model_q[0]));
            void'(model_q.pop_front());
            model_q.push_back(b);
            drive(1, b, 0, 1, 0);
            if (count != 5'd3) check($sformatf("pair_cnt_%0d", i), int'(count), 3);
        end
        check("pairs_count", int'(count), 3);
        while (model_q.size() > 0) begin
            check("pairs_tail", int'(rd_data), int'(model_q[0]));
            void'(model_q.pop_front());
            drive(0, 8'h00, 0, 1, 0);
        end
        check("pairs_empty", int'(rd_valid), 0);

        // asynchronous reset mid-cycle with COUNT=5
        for (int i = 0; i < 5; i++) drive(1, 8'h50 + 8'(i), 0, 0, 0);
        check("pre_rst_count", int'(count), 5);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_valid", int'(rd_valid), 0);
        check("mid_rst_ovr", int'(overrun), 0);
        wr_valid = 1'b1; wr_data = 8'hEE;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check("wr_during_rst", int'(count), 0);
        rst = 1'b0;
        drive(1, 8'h5A, 0, 0, 0);
        check("first_wr_count", int'(count), 1);
        check("first_wr_data", int'(rd_data), 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of byte entries; power of two, 2..256.
REQ-002 Parameter: AW, log2(DEPTH), pointer width; COUNT width is AW+1.
REQ-003 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous, active-high.
REQ-005 Port: WR_VALID  input  1  one-cycle strobe from receiver: byte complete.
REQ-006 Port: WR_DATA  input  8  received byte, sampled when WR_VALID=1.
REQ-007 Port: WR_FRAME_ERR  input  1  receiver stop-bit error for this byte, sampled with WR_VALID.
REQ-008 Port: RD_READY  input  1  consumer accepts RD_DATA this cycle.
REQ-009 Port: RD_VALID  output  1  RD_DATA holds the oldest stored byte.
REQ-010 Port: RD_DATA  output  8  oldest byte, show-ahead (no read latency).
REQ-011 Port: COUNT  output  AW+1  number of stored bytes, 0..DEPTH.
REQ-012 Port: FULL  output  1  COUNT==DEPTH.
REQ-013 Port: OVERRUN  output  1  sticky: a byte was lost because the FIFO was full.
REQ-014 Port: CLR_OVERRUN  input  1  clears OVERRUN.
REQ-015 Port: ERR_DROP  output  1  one-cycle pulse: an errored byte was discarded (see Configuration).

Function
REQ-016 Write accept: WR_VALID=1 and (FULL=0, or a read occurs in the same cycle) stores WR_DATA at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-017 Read: transfer occurs when RD_VALID=1 and RD_READY=1; rd_ptr increments modulo DEPTH.
REQ-018 RD_VALID SHALL equal (COUNT!=0); RD_DATA SHALL be mem[rd_ptr]; RD_DATA is don't-care when RD_VALID=0.
REQ-019 Write-to-read latency: a byte written into an empty FIFO at edge N SHALL be visible with RD_VALID=1 after edge N.
REQ-020 COUNT: +1 on write only, -1 on read only, unchanged on simultaneous read and write or on neither.
REQ-021 Full with simultaneous read and write: both SHALL occur; COUNT stays DEPTH; OVERRUN not set.
REQ-022 Full with write and no read: byte dropped; storage, pointers and COUNT unchanged; OVERRUN SHALL be 1 after that edge.
REQ-023 Empty: RD_READY ignored; pointers never advance past wr_ptr; COUNT never underflows.
REQ-024 OVERRUN: set by REQ-022 and cleared by CLR_OVERRUN=1; if both occur in the same cycle, set wins.
REQ-025 Pointer wrap: pointers wrap from DEPTH-1 to 0 with no gap or duplicated byte; FIFO order is preserved across the wrap.
REQ-026 All outputs SHALL be registered or derived only from registered state; there is no combinational path from WR_* to RD_*.

Reset
REQ-027 RST=1 SHALL immediately clear wr_ptr, rd_ptr, COUNT, OVERRUN and ERR_DROP; RD_VALID=0 and FULL=0; memory contents are not cleared.
REQ-028 Reset mid-operation SHALL discard all stored bytes; a WR_VALID coincident with RST is ignored.
REQ-029 The first write is accepted on the first rising edge after RST is deasserted.

Configuration
REQ-030 Macro RX_FIFO_DROP_ERR_EN: when defined, a write with WR_FRAME_ERR=1 is not stored, does not affect COUNT or OVERRUN, and pulses ERR_DROP=1 for one cycle.
REQ-031 Without RX_FIFO_DROP_ERR_EN, WR_FRAME_ERR is ignored, errored bytes are stored normally, and ERR_DROP is tied to 0.

Verification
REQ-032 Reset, then write 0x95, then 0x3C with RD_READY=0 -> COUNT=2, RD_VALID=1, RD_DATA=0x95; then RD_READY=1 for 2 cycles -> reads 0x95 then 0x3C, COUNT=0.
REQ-033 DEPTH=16: write 17 bytes 0x00..0x10 with no reads -> FULL=1, COUNT=16, OVERRUN=1; reading out yields 0x00..0x0F, and 0x10 is lost.
REQ-034 When full, write 0xAA with RD_READY=1 in the same cycle -> COUNT stays 16, OVERRUN=0, 0xAA is the last byte read out.
REQ-035 Run 40 write/read pairs with COUNT held at 3 (wraps both pointers) -> output sequence equals input sequence exactly.
REQ-036 Assert RST asynchronously between edges with COUNT=5 -> COUNT=0, RD_VALID=0, OVERRUN=0 before the next edge.
REQ-037 With RX_FIFO_DROP_ERR_EN defined, write 0x41 with WR_FRAME_ERR=1 -> ERR_DROP pulses for 1 cycle, COUNT unchanged; without the macro -> 0x41 is stored and ERR_DROP=0.
